// File: rtl/tx_scheduler_pkg.sv
// Shared definitions for the tx scheduler: FSM encoding and the default
// frame length derived from the tx serialiser timing.
package tx_scheduler_pkg;

  // tx frame: start + 8 data + parity + stop, 16 clocks per bit
  localparam int TX_FRAME_BITS    = 11;
  localparam int TX_CLKS_PER_BIT  = 16;
  localparam int TX_FRAME_CYCLES  = TX_FRAME_BITS * TX_CLKS_PER_BIT;

  typedef enum logic [2:0] {
    ST_FLUSH = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SEND  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GAP   = 3'd4
  } sched_state_e;

endpackage

// File: rtl/tx_scheduler_if.sv
// Client-side bus of the tx scheduler: requests/bytes in, grant status out.
interface tx_scheduler_if #(
  parameter int N_REQ = 3
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]   Req;
  logic [8*N_REQ-1:0] DataIn;
  logic [N_REQ-1:0]   Ack;
  logic [N_REQ-1:0]   Done;
  logic               Send;
  logic [7:0]         PDataOut;
  logic [IDX_W-1:0]   GrantIdx;
  logic               Busy;

  modport master (
    output Req, DataIn,
    input  Ack, Done, Send, PDataOut, GrantIdx, Busy
  );

  modport slave (
    input  Req, DataIn,
    output Ack, Done, Send, PDataOut, GrantIdx, Busy
  );
endinterface

// File: rtl/tx_scheduler_rr_picker.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_picker #(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] winner
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0] rot;

  // rotate so bit 0 is the requester just after ptr
  always_comb begin
    rot = '0;
    for (int k = 0; k < N_REQ; k++)
      rot[k] = req[IDX_W'((int'(ptr) + 1 + k) % N_REQ)];
  end

  // priority-encode lowest rotated bit, then map back to requester index
  always_comb begin
    valid  = |rot;
    winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (rot[k]) winner = IDX_W'((int'(ptr) + 1 + k) % N_REQ);
  end
endmodule

// File: rtl/tx_scheduler.sv
// Shares one tx serialiser among N_REQ requesters. Grants round-robin,
// holds Send for SEND_HOLD cycles, times the frame with a local counter
// (tx has no busy flag) and enforces an idle gap between frames.
module tx_scheduler
  import tx_scheduler_pkg::*;
#(
  parameter int N_REQ        = 3,
  parameter int SEND_HOLD    = 2,
  parameter int FRAME_CYCLES = TX_FRAME_CYCLES,
  parameter int GAP_CYCLES   = 2
) (
  input  logic           Clock,
  input  logic           Reset,
  tx_scheduler_if.slave  bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(FRAME_CYCLES + GAP_CYCLES + 1);

  localparam logic [CNT_W-1:0] SEND_END  = CNT_W'(SEND_HOLD - 1);
  localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(FRAME_CYCLES + GAP_CYCLES - 1);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [7:0]       pdata_q, pdata_d;
  logic             send_q, send_d;
  logic             busy_q, busy_d;

  logic             pick_vld;
  logic [IDX_W-1:0] pick_idx;
  logic [7:0]       pick_byte;

  rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req    (bus.Req),
    .ptr    (ptr_q),
    .valid  (pick_vld),
    .winner (pick_idx)
  );

  assign pick_byte = bus.DataIn[8*int'(pick_idx) +: 8];

  // next-state, counter and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    pdata_d = pdata_q;
    send_d  = send_q;
    busy_d  = busy_q;
    ack_d   = '0;
    done_d  = '0;
    unique case (state_q)
      // drain any frame tx started before reset; requests ignored
      ST_FLUSH: begin
        if (cnt_q == FRAME_END) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (pick_vld) begin
          state_d         = ST_SEND;
          pdata_d         = pick_byte;
          grant_d         = pick_idx;
          ptr_d           = pick_idx;
          ack_d[pick_idx] = 1'b1;
          send_d          = 1'b1;
          busy_d          = 1'b1;
          cnt_d           = '0;
        end
      end
      ST_SEND: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SEND_END) begin
          send_d  = 1'b0;
          state_d = ST_WAIT;
        end
      end
      // counter keeps running from the Send rise so Done lands on t0+FRAME_CYCLES
      ST_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FRAME_END) begin
          done_d[grant_q] = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == GAP_END) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_FLUSH;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  // state and output registers, synchronous reset
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_FLUSH;
      cnt_q   <= '0;
      ptr_q   <= IDX_W'(N_REQ - 1);
      grant_q <= '0;
      pdata_q <= 8'h00;
      send_q  <= 1'b0;
      busy_q  <= 1'b1;
      ack_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      pdata_q <= pdata_d;
      send_q  <= send_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  assign bus.Send     = send_q;
  assign bus.PDataOut = pdata_q;
  assign bus.GrantIdx = grant_q;
  assign bus.Busy     = busy_q;
  assign bus.Ack      = ack_q;
  assign bus.Done     = done_q;
endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler (N_REQ=3, SEND_HOLD=2, FRAME=20, GAP=2).
module tb_tx_scheduler;
  logic Clock = 1'b0;
  logic Reset = 1'b1;

  tx_scheduler_if #(.N_REQ(3)) bus ();

  tx_scheduler #(
    .N_REQ(3), .SEND_HOLD(2), .FRAME_CYCLES(20), .GAP_CYCLES(2)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // advance one cycle; sample point is 1ns after the rising edge
  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
    if (bus.Done != 0) done_cnt++;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_send(output int at);
    int n = 0;
    while (bus.Send !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    at = (bus.Send === 1'b1) ? cyc : -1;
  endtask

  // called in cycle t0 (Send just rose); returns in cycle t0+22
  task automatic frame_check(input logic [2:0] exp_done);
    int dn;
    chk("f_send_t0", 32'(bus.Send), 32'd1);
    tick();
    chk("f_send_t1", 32'(bus.Send), 32'd1);
    chk("f_ack_t1", 32'(bus.Ack), 32'd0);
    tick();
    chk("f_send_t2", 32'(bus.Send), 32'd0);
    dn = done_cnt;
    repeat (17) tick();
    chk("f_early_done", 32'(done_cnt - dn), 32'd0);
    tick();
    chk("f_done", 32'(bus.Done), 32'(exp_done));
    chk("f_busy_t20", 32'(bus.Busy), 32'd1);
    tick();
    chk("f_done_clr", 32'(bus.Done), 32'd0);
    chk("f_busy_t21", 32'(bus.Busy), 32'd1);
    tick();
    chk("f_idle_t22", 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    int at, bz, dn;
    logic [7:0] exp_b [5];
    logic [1:0] exp_i [5];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22};
    exp_i = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

    bus.Req    = '0;
    bus.DataIn = '0;
    repeat (3) @(posedge Clock);

    // flush with Req[0] held from reset release
    bus.Req = 3'b001;
    do_reset();
    chk("rst_send", 32'(bus.Send), 32'd0);
    chk("rst_pdata", 32'(bus.PDataOut), 32'h00);
    chk("rst_ack", 32'(bus.Ack), 32'd0);
    chk("rst_done", 32'(bus.Done), 32'd0);
    chk("rst_grant", 32'(bus.GrantIdx), 32'd0);
    chk("rst_busy", 32'(bus.Busy), 32'd1);
    bz = 0;
    while (cyc < 20) begin
      if (bus.Busy !== 1'b1 || bus.Send !== 1'b0 || bus.Ack != 0) bz++;
      tick();
    end
    chk("flush_hold", 32'(bz), 32'd0);
    chk("flush_end_busy", 32'(bus.Busy), 32'd0);
    chk("flush_end_send", 32'(bus.Send), 32'd0);
    wait_send(at);
    chk("flush_send_cyc", 32'(at), 32'd21);
    chk("flush_ack", 32'(bus.Ack), 32'b001);
    chk("flush_grant", 32'(bus.GrantIdx), 32'd0);
    bus.Req = '0;
    frame_check(3'b001);

    // single grant to requester 1
    bus.DataIn[15:8] = 8'hA5;
    bus.Req = 3'b010;
    tick();
    bus.Req = '0;
    chk("single_send", 32'(bus.Send), 32'd1);
    chk("single_pdata", 32'(bus.PDataOut), 32'hA5);
    chk("single_grant", 32'(bus.GrantIdx), 32'd1);
    chk("single_ack", 32'(bus.Ack), 32'b010);
    frame_check(3'b010);

    // data hold: DataIn changes one cycle after Ack
    bus.DataIn[7:0] = 8'h3C;
    bus.Req = 3'b001;
    tick();
    bus.Req = '0;
    chk("hold_ack", 32'(bus.Ack), 32'b001);
    chk("hold_pdata0", 32'(bus.PDataOut), 32'h3C);
    tick();
    bus.DataIn[7:0] = 8'hFF;
    repeat (4) tick();
    chk("hold_pdata5", 32'(bus.PDataOut), 32'h3C);
    repeat (17) tick();
    chk("hold_idle", 32'(bus.Busy), 32'd0);
    chk("hold_pdata22", 32'(bus.PDataOut), 32'h3C);
    bus.Req = 3'b001;
    tick();
    bus.Req = '0;
    chk("hold_regrant_send", 32'(bus.Send), 32'd1);
    chk("hold_regrant_pdata", 32'(bus.PDataOut), 32'hFF);
    repeat (22) tick();
    chk("hold_regrant_idle", 32'(bus.Busy), 32'd0);

    // round-robin from reset, then wrap fairness with Req=011
    bus.DataIn = {8'h33, 8'h22, 8'h11};
    bus.Req = 3'b111;
    do_reset();
    for (int g = 0; g < 5; g++) begin
      wait_send(at);
      chk($sformatf("rr_cyc%0d", g), 32'(at), 32'(21 + 23*g));
      chk($sformatf("rr_pdata%0d", g), 32'(bus.PDataOut), 32'(exp_b[g]));
      chk($sformatf("rr_grant%0d", g), 32'(bus.GrantIdx), 32'(exp_i[g]));
      chk($sformatf("rr_ack%0d", g), 32'(bus.Ack), 32'(3'b001 << exp_i[g]));
      if (g == 2) bus.Req = 3'b011;
      if (g == 4) bus.Req = '0;
      tick();
      tick();
    end
    repeat (20) tick();
    chk("rr_idle", 32'(bus.Busy), 32'd0);

    // mid-frame reset at t0+5
    bus.Req = 3'b010;
    tick();
    chk("mr_send", 32'(bus.Send), 32'd1);
    repeat (5) tick();
    dn = done_cnt;
    do_reset();
    chk("mr_send_rst", 32'(bus.Send), 32'd0);
    chk("mr_busy_rst", 32'(bus.Busy), 32'd1);
    chk("mr_grant_rst", 32'(bus.GrantIdx), 32'd0);
    wait_send(at);
    chk("mr_no_done", 32'(done_cnt - dn), 32'd0);
    chk("mr_send_cyc", 32'(at), 32'd21);
    chk("mr_ack", 32'(bus.Ack), 32'b010);
    chk("mr_grant", 32'(bus.GrantIdx), 32'd1);
    bus.Req = '0;
    frame_check(3'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
